// File: rtl/reg_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_access_pkg
// Description : Shared widths, FSM state type and command record for the
//               register-access sequencer.
// Revision    : 1.0 - initial release
// ============================================================================

package reg_access_pkg;

    localparam int DATA_W_DEFAULT = 16;
    localparam int ADDR_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    // Sized by the package defaults; the sequencer's DATA_W/ADDR_W must match.
    typedef struct packed {
        logic [ADDR_W_DEFAULT-1:0] ra;
        logic [ADDR_W_DEFAULT-1:0] rb;
        logic [ADDR_W_DEFAULT-1:0] rd;
        logic                      wb;
        logic                      imm_sel;
        logic [DATA_W_DEFAULT-1:0] imm;
    } cmd_t;

endpackage

`default_nettype wire

// File: rtl/reg_access_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_access_seq_if
// Description : Command, register-file and ALU signal bundle of the
//               register-access sequencer (master = sequencer side).
// Revision    : 1.0 - initial release
// ============================================================================

interface reg_access_seq_if #(
    parameter int DATA_W = reg_access_pkg::DATA_W_DEFAULT,
    parameter int ADDR_W = reg_access_pkg::ADDR_W_DEFAULT
) ();

    // command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_ra;
    logic [ADDR_W-1:0] cmd_rb;
    logic [ADDR_W-1:0] cmd_rd;
    logic              cmd_wb;
    logic              cmd_imm_sel;
    logic [DATA_W-1:0] cmd_imm;

    // register file
    logic [ADDR_W-1:0] rf_a;
    logic [ADDR_W-1:0] rf_b;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;
    logic [ADDR_W-1:0] rf_c;
    logic              rf_write;
    logic [DATA_W-1:0] rf_wdata;

    // ALU
    logic              alu_start;
    logic [DATA_W-1:0] alu_opa;
    logic [DATA_W-1:0] alu_opb;
    logic              alu_done;
    logic [DATA_W-1:0] alu_result;

    modport master (
        input  cmd_valid,
        input  cmd_ra,
        input  cmd_rb,
        input  cmd_rd,
        input  cmd_wb,
        input  cmd_imm_sel,
        input  cmd_imm,
        output cmd_ready,
        output rf_a,
        output rf_b,
        input  rf_rdata1,
        input  rf_rdata2,
        output rf_c,
        output rf_write,
        output rf_wdata,
        output alu_start,
        output alu_opa,
        output alu_opb,
        input  alu_done,
        input  alu_result
    );

    modport slave (
        output cmd_valid,
        output cmd_ra,
        output cmd_rb,
        output cmd_rd,
        output cmd_wb,
        output cmd_imm_sel,
        output cmd_imm,
        input  cmd_ready,
        input  rf_a,
        input  rf_b,
        output rf_rdata1,
        output rf_rdata2,
        input  rf_c,
        input  rf_write,
        input  rf_wdata,
        input  alu_start,
        input  alu_opa,
        input  alu_opb,
        output alu_done,
        output alu_result
    );

endinterface

`default_nettype wire

// File: rtl/reg_access_seq.sv
`default_nettype none
// ============================================================================
// Module      : reg_access_seq
// Description : Register-access sequencer: read two operands, hand them to an
//               ALU, optionally write the result back. Optional immediate
//               operand B selected with REG_ACCESS_SEQ_IMM_EN.
// Revision    : 1.0 - initial release
// ============================================================================

module reg_access_seq #(
    parameter int DATA_W = reg_access_pkg::DATA_W_DEFAULT,
    parameter int ADDR_W = reg_access_pkg::ADDR_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    reg_access_seq_if.master bus,
    output logic             busy,
    output logic [15:0]      wb_count
);

    import reg_access_pkg::*;

    state_t            r_state;
    state_t            w_next;
    logic              w_cmd_ready;
    logic              w_busy;

    cmd_t              r_cmd;
    logic [DATA_W-1:0] r_opa;
    logic [DATA_W-1:0] r_opb;
    logic [DATA_W-1:0] r_result;
    logic              r_alu_start;
    logic              r_rf_write;
    logic [15:0]       r_wb_count;

    logic              w_accept;
    logic              w_done;
    logic              w_wb_fire;
    logic [DATA_W-1:0] w_opb_src;

    assign w_accept  = (r_state == IDLE) && bus.cmd_valid;
    assign w_done    = (r_state == EXEC) && bus.alu_done;
    assign w_wb_fire = w_done && r_cmd.wb;

`ifdef REG_ACCESS_SEQ_IMM_EN
    assign w_opb_src = r_cmd.imm_sel ? r_cmd.imm : bus.rf_rdata2;
`else
    logic w_unused_imm;
    assign w_unused_imm = ^{r_cmd.imm_sel, r_cmd.imm};
    assign w_opb_src    = bus.rf_rdata2;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cmd_ready = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            IDLE: begin
                w_cmd_ready = 1'b1;
                w_busy      = 1'b0;
                if (bus.cmd_valid) begin
                    w_next = READ;
                end
            end
            READ: begin
                w_next = EXEC;
            end
            EXEC: begin
                if (bus.alu_done) begin
                    w_next = r_cmd.wb ? WB : IDLE;
                end
            end
            WB: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operands are captured on the READ->EXEC edge, so a write-back to ra/rb
    // of the same command can never be seen by its own operands.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cmd       <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_result    <= '0;
            r_alu_start <= 1'b0;
            r_rf_write  <= 1'b0;
            r_wb_count  <= '0;
        end else begin
            r_alu_start <= (r_state == READ);
            r_rf_write  <= w_wb_fire;
            if (w_accept) begin
                r_cmd <= '{ra:      bus.cmd_ra,
                           rb:      bus.cmd_rb,
                           rd:      bus.cmd_rd,
                           wb:      bus.cmd_wb,
                           imm_sel: bus.cmd_imm_sel,
                           imm:     bus.cmd_imm};
            end
            if (r_state == READ) begin
                r_opa <= bus.rf_rdata1;
                r_opb <= w_opb_src;
            end
            if (w_done) begin
                r_result <= bus.alu_result;
            end
            if (w_wb_fire) begin
                r_wb_count <= r_wb_count + 16'd1;
            end
        end
    end

    assign bus.cmd_ready = w_cmd_ready && reset;
    assign bus.rf_a      = r_cmd.ra;
    assign bus.rf_b      = r_cmd.rb;
    assign bus.rf_c      = r_cmd.rd;
    assign bus.rf_write  = r_rf_write;
    assign bus.rf_wdata  = r_result;
    assign bus.alu_start = r_alu_start;
    assign bus.alu_opa   = r_opa;
    assign bus.alu_opb   = r_opb;
    assign busy          = w_busy;
    assign wb_count      = r_wb_count;

endmodule

`default_nettype wire

// File: tb/tb_reg_access_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_access_seq
// Description : Self-checking bench for reg_access_seq against a command-level
//               register-file model. Honours REG_ACCESS_SEQ_IMM_EN.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_reg_access_seq;

    import reg_access_pkg::*;

    localparam int DW   = DATA_W_DEFAULT;
    localparam int AW   = ADDR_W_DEFAULT;
    localparam int NREG = 1 << AW;
`ifdef REG_ACCESS_SEQ_IMM_EN
    localparam bit IMM_EN = 1'b1;
`else
    localparam bit IMM_EN = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        busy;
    logic [15:0] wb_count;

    reg_access_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    reg_access_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .wb_count (wb_count)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] phys_rf  [NREG];
    logic [DW-1:0] model_rf [NREG];
    logic          load_en   = 1'b0;
    int            n_wr_seen = 0;

    always @(posedge clk) begin
        if (load_en) begin
            phys_rf <= model_rf;
        end else if (bus.rf_write) begin
            phys_rf[bus.rf_c] <= bus.rf_wdata;
        end
        if (bus.rf_write) begin
            n_wr_seen <= n_wr_seen + 1;
        end
    end

    assign bus.rf_rdata1 = phys_rf[bus.rf_a];
    assign bus.rf_rdata2 = phys_rf[bus.rf_b];

    int          n_cmp  = 0;
    int          n_bad  = 0;
    int          exp_wr = 0;
    logic [15:0] exp_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rf();
        load_en = 1'b1;
        tick();
        load_en = 1'b0;
    endtask

    // One command, start to finish; expected values come from model_rf.
    task automatic run_cmd(input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                           input logic [AW-1:0] rd, input logic wb,
                           input logic isel, input logic [DW-1:0] imm,
                           input int dly, input logic [DW-1:0] result,
                           input logic keep_valid);
        logic [DW-1:0] exp_opa;
        logic [DW-1:0] exp_opb;
        int            waited;
        exp_opa = model_rf[ra];
        exp_opb = (IMM_EN && isel) ? imm : model_rf[rb];

        bus.cmd_valid   = 1'b1;
        bus.cmd_ra      = ra;
        bus.cmd_rb      = rb;
        bus.cmd_rd      = rd;
        bus.cmd_wb      = wb;
        bus.cmd_imm_sel = isel;
        bus.cmd_imm     = imm;
        waited = 0;
        while (!bus.cmd_ready && waited < 40) begin
            tick();
            waited++;
        end
        check_eq("accept_ready", 32'(bus.cmd_ready), 32'd1);
        tick();

        if (keep_valid) begin
            bus.cmd_ra      = AW'($urandom);
            bus.cmd_rb      = AW'($urandom);
            bus.cmd_rd      = AW'($urandom);
            bus.cmd_wb      = 1'($urandom);
            bus.cmd_imm_sel = 1'($urandom);
            bus.cmd_imm     = DW'($urandom);
        end else begin
            bus.cmd_valid = 1'b0;
        end
        // alu_done outside EXEC must have no effect
        bus.alu_done   = 1'($urandom);
        bus.alu_result = DW'($urandom);
        check_eq("read_busy",  32'(busy),          32'd1);
        check_eq("read_ready", 32'(bus.cmd_ready), 32'd0);
        check_eq("read_rf_a",  32'(bus.rf_a),      32'(ra));
        check_eq("read_rf_b",  32'(bus.rf_b),      32'(rb));
        check_eq("read_start", 32'(bus.alu_start), 32'd0);
        tick();
        bus.alu_done = 1'b0;

        for (int k = 0; k <= dly; k++) begin
            check_eq("exec_start", 32'(bus.alu_start), 32'(k == 0));
            check_eq("exec_opa",   32'(bus.alu_opa),   32'(exp_opa));
            check_eq("exec_opb",   32'(bus.alu_opb),   32'(exp_opb));
            check_eq("exec_write", 32'(bus.rf_write),  32'd0);
            check_eq("exec_ready", 32'(bus.cmd_ready), 32'd0);
            check_eq("exec_rf_a",  32'(bus.rf_a),      32'(ra));
            bus.alu_done   = (k == dly);
            bus.alu_result = (k == dly) ? result : DW'($urandom);
            tick();
            bus.alu_done = 1'b0;
        end
        bus.cmd_valid = 1'b0;

        if (wb) begin
            model_rf[rd] = result;
            exp_cnt++;
            exp_wr++;
            check_eq("wb_write", 32'(bus.rf_write),  32'd1);
            check_eq("wb_rf_c",  32'(bus.rf_c),      32'(rd));
            check_eq("wb_wdata", 32'(bus.rf_wdata),  32'(result));
            check_eq("wb_busy",  32'(busy),          32'd1);
            check_eq("wb_ready", 32'(bus.cmd_ready), 32'd0);
            tick();
        end
        check_eq("idle_write", 32'(bus.rf_write),  32'd0);
        check_eq("idle_ready", 32'(bus.cmd_ready), 32'd1);
        check_eq("idle_busy",  32'(busy),          32'd0);
        check_eq("idle_count", 32'(wb_count),      32'(exp_cnt));
    endtask

    task automatic check_all_zero(input string where);
        check_eq({where, "_rf_write"},  32'(bus.rf_write),  32'd0);
        check_eq({where, "_alu_start"}, 32'(bus.alu_start), 32'd0);
        check_eq({where, "_busy"},      32'(busy),          32'd0);
        check_eq({where, "_wb_count"},  32'(wb_count),      32'd0);
        check_eq({where, "_opa"},       32'(bus.alu_opa),   32'd0);
        check_eq({where, "_opb"},       32'(bus.alu_opb),   32'd0);
        check_eq({where, "_rf_a"},      32'(bus.rf_a),      32'd0);
        check_eq({where, "_rf_b"},      32'(bus.rf_b),      32'd0);
        check_eq({where, "_rf_c"},      32'(bus.rf_c),      32'd0);
        check_eq({where, "_rf_wdata"},  32'(bus.rf_wdata),  32'd0);
        check_eq({where, "_ready"},     32'(bus.cmd_ready), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid   = 1'b0;
        bus.cmd_ra      = '0;
        bus.cmd_rb      = '0;
        bus.cmd_rd      = '0;
        bus.cmd_wb      = 1'b0;
        bus.cmd_imm_sel = 1'b0;
        bus.cmd_imm     = '0;
        bus.alu_done    = 1'b0;
        bus.alu_result  = '0;
        exp_cnt         = '0;
        for (int i = 0; i < NREG; i++) begin
            model_rf[i] = DW'($urandom);
        end

        // Reset state
        reset = 1'b0;
        load_rf();
        repeat (2) tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();
        check_eq("release_ready", 32'(bus.cmd_ready), 32'd1);
        check_eq("release_busy",  32'(busy),          32'd0);

        // Write-back path, minimum latency
        model_rf[3] = 16'h0012;
        model_rf[4] = 16'h0034;
        load_rf();
        run_cmd(4'd3, 4'd4, 4'd5, 1'b1, 1'b0, 16'h0, 0, 16'h0046, 1'b0);
        check_eq("wbpath_count", 32'(wb_count), 32'd1);

        // No write-back, done after three EXEC cycles
        run_cmd(4'd1, 4'd2, 4'd6, 1'b0, 1'b0, 16'h0, 3, 16'hAAAA, 1'b0);

        // Stalled ALU with cmd_valid held high
        run_cmd(4'd5, 4'd3, 4'd9, 1'b1, 1'b0, 16'h0, 10, 16'h5A5A, 1'b1);

        // Immediate operand
        model_rf[2] = 16'h1111;
        load_rf();
        run_cmd(4'd1, 4'd2, 4'd8, 1'b1, 1'b1, 16'hBEEF, 1, 16'h0101, 1'b0);

        // Reset abort during EXEC with alu_done pending
        bus.cmd_valid = 1'b1;
        bus.cmd_ra    = 4'd1;
        bus.cmd_rb    = 4'd2;
        bus.cmd_rd    = 4'd10;
        bus.cmd_wb    = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        check_eq("abort_start", 32'(bus.alu_start), 32'd1);
        reset          = 1'b0;
        bus.alu_done   = 1'b1;
        bus.alu_result = 16'hDEAD;
        tick();
        check_all_zero("abort");
        tick();
        reset = 1'b1;
        tick();
        exp_cnt = '0;
        check_eq("abort_ready", 32'(bus.cmd_ready), 32'd1);
        check_eq("abort_busy",  32'(busy),          32'd0);
        check_eq("abort_write", 32'(bus.rf_write),  32'd0);
        bus.alu_done = 1'b0;

        // Randomized commands
        for (int n = 0; n < 40; n++) begin
            run_cmd(AW'($urandom), AW'($urandom), AW'($urandom), 1'($urandom),
                    1'($urandom), DW'($urandom), $urandom_range(0, 4),
                    DW'($urandom), 1'($urandom));
        end

        // Counter wrap; last command reads and writes R7
        force dut.r_wb_count = 16'hFFFE;
        #1;
        release dut.r_wb_count;
        exp_cnt = 16'hFFFE;
        tick();
        check_eq("wrap_preset", 32'(wb_count), 32'hFFFE);
        run_cmd(4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 16'h0, 0, 16'h1234, 1'b0);
        model_rf[7] = 16'h7777;
        load_rf();
        run_cmd(4'd7, 4'd1, 4'd7, 1'b1, 1'b0, 16'h0, 0, 16'h4321, 1'b0);
        check_eq("wrap_zero", 32'(wb_count), 32'h0000);

        // Register file contents and write count
        for (int i = 0; i < NREG; i++) begin
            check_eq("rf_final", 32'(phys_rf[i]), 32'(model_rf[i]));
        end
        check_eq("write_pulses", 32'(n_wr_seen), 32'(exp_wr));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reg_access_seq.md
REG_ACCESS_SEQ -- requirements
Module: reg_access_seq

Interface
REQ-001 Parameter: DATA_W, default 16, register data width.
REQ-002 Parameter: ADDR_W, default 4, register select width (16 registers).
REQ-003 One clock; reset is synchronous and active-low. Ports are named clk and reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  sequencer can accept a command.
REQ-008 cmd_ra  in  ADDR_W  operand-A register select.
REQ-009 cmd_rb  in  ADDR_W  operand-B register select.
REQ-010 cmd_rd  in  ADDR_W  destination register select.
REQ-011 cmd_wb  in  1  1 = write the result back; 0 = discard it (compare-type op).
REQ-012 cmd_imm_sel, cmd_imm  in  1, DATA_W  immediate operand-B select and value (used only with the macro in REQ-030).
REQ-013 rf_a, rf_b  out  ADDR_W  register-file read selects.
REQ-014 rf_rdata1, rf_rdata2  in  DATA_W  combinational read data for rf_a and rf_b.
REQ-015 rf_c, rf_write, rf_wdata  out  ADDR_W, 1, DATA_W  register-file write select, write strobe and write data.
REQ-016 alu_start  out  1  one-cycle pulse: the operands are valid.
REQ-017 alu_opa, alu_opb  out  DATA_W  latched operands, held stable until the sequencer returns to IDLE.
REQ-018 alu_done, alu_result  in  1, DATA_W  ALU completion and result.
REQ-019 busy  out  1  high in every state other than IDLE.
REQ-020 wb_count  out  16  number of completed write-backs; wraps from 0xFFFF to 0.

Function
REQ-021 The FSM has four states: IDLE, READ, EXEC, WB.
- IDLE -> READ on cmd_valid && cmd_ready.
- READ -> EXEC always.
- EXEC -> WB on alu_done when the latched cmd_wb = 1.
- EXEC -> IDLE on alu_done when the latched cmd_wb = 0.
- WB -> IDLE always.
REQ-022 cmd_ready is 1 only in IDLE. On acceptance, ra, rb, rd, wb, imm_sel and imm are latched.
REQ-023 In READ, rf_a and rf_b carry the latched selects. rf_rdata1 and rf_rdata2 are captured into alu_opa and alu_opb at the end of READ.
REQ-024 At all other times rf_a and rf_b hold their last value. They are don't-care to the register file.
REQ-025 alu_start is high for exactly the first EXEC cycle. alu_done is sampled in every EXEC cycle, including the first; alu_done outside EXEC is ignored.
REQ-026 The alu_result present with alu_done is latched.
- In WB: rf_write = 1 for exactly one cycle, rf_c = latched rd, rf_wdata = latched result.
- wb_count increments on that same cycle.
REQ-027 rf_write is 0 in every state except WB.
REQ-028 Minimum latency is 4 cycles from the acceptance edge to the rf_write cycle (alu_done in the first EXEC cycle). Minimum command spacing is 4 cycles with write-back and 3 cycles without.
REQ-029 rd may equal ra or rb. The write occurs after operand capture, so the operands see the old value.

Configuration
REQ-030 With REG_ACCESS_SEQ_IMM_EN defined, alu_opb is captured from the latched cmd_imm when the latched imm_sel = 1, and from rf_rdata2 otherwise.
REQ-031 Without REG_ACCESS_SEQ_IMM_EN, cmd_imm_sel and cmd_imm are ignored and alu_opb always comes from rf_rdata2.

Reset
REQ-032 While reset = 0 at a clock edge, the following outputs are 0 after that edge, and the state is IDLE:
- rf_write, alu_start, busy, wb_count, alu_opa, alu_opb;
- rf_a, rf_b, rf_c, rf_wdata.
REQ-033 cmd_ready is 0 while reset is asserted and 1 in the first cycle after release.
REQ-034 A reset in any state aborts the operation. No rf_write is issued for the aborted command, and a pending alu_done is ignored.

Structure
REQ-035 Package reg_access_pkg holds:
- the DATA_W and ADDR_W defaults;
- the state enum typedef {IDLE, READ, EXEC, WB};
- a command struct typedef (ra, rb, rd, wb, imm_sel, imm).
REQ-036 The design is a single module. No sub-module is needed; the FSM, operand latches and counter are inline.

Verification
REQ-037 Write-back path: preload R3=0x0012, R4=0x0034; command ra=3, rb=4, rd=5, wb=1; alu_done in the first EXEC cycle with result 0x0046 -> alu_opa=0x0012, alu_opb=0x0034, one rf_write pulse with c=5, wdata=0x0046, 4 cycles after acceptance; wb_count=1.
REQ-038 No write-back: cmd_wb=0; alu_done after 3 EXEC cycles -> no rf_write; cmd_ready returns 1 the cycle after alu_done; wb_count unchanged.
REQ-039 Stalled ALU: alu_done held off 10 cycles -> alu_start pulses once; alu_opa and alu_opb stay stable; cmd_valid held high is not accepted until IDLE.
REQ-040 Reset abort: reset=0 during EXEC, then alu_done=1 -> no rf_write; all outputs are 0; cmd_ready=1 the cycle after release.
REQ-041 Immediate path (with the macro): imm_sel=1, imm=0xBEEF, R2=0x1111, rb=2 -> alu_opb=0xBEEF. Without the macro, the same stimulus gives alu_opb=0x1111.
REQ-042 Counter wrap: force 65536 back-to-back write-back commands -> wb_count wraps to 0x0000; rd=ra=7 reads the old R7 value.
